// File: rtl/func_pkg.sv
// Shared vector-word layout, operand/result widths and sequencer state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package func_pkg;

    localparam int A_MSB   = 31;
    localparam int B_MSB   = 23;
    localparam int EXP_MSB = 15;
    localparam int OP_W    = 8;
    localparam int RES_W   = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LAUNCH = 3'd2,
        WAIT   = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5
    } state_e;

endpackage

// File: rtl/func_seq.sv
// Self-test initiator: walks {a,b,expected} vectors, launches the engine, scores results (FUNC_SEQ_TIMEOUT_EN adds a busy watchdog).
// Latency: first eng_start 2 cycles after run; per vector 4 cycles plus engine busy time.
// Backpressure: waits on eng_busy indefinitely (or up to TIMEOUT cycles with the watchdog); run ignored unless idle.
module func_seq
    import func_pkg::*;
#(
    parameter int NUM_VEC = 10,
    parameter int ADDR_W  = 4
`ifdef FUNC_SEQ_TIMEOUT_EN
    , parameter int TIMEOUT = 1024
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic [ADDR_W-1:0] vec_addr,
    input  logic [31:0]       vec_data,
    output logic              eng_start,
    output logic [OP_W-1:0]   eng_a,
    output logic [OP_W-1:0]   eng_b,
    input  logic              eng_busy,
    input  logic [RES_W-1:0]  eng_result,
    output logic              seq_busy,
    output logic              done,
    output logic [ADDR_W:0]   err_count,
    output logic              fail_valid,
    output logic [ADDR_W-1:0] fail_idx
`ifdef FUNC_SEQ_TIMEOUT_EN
    , output logic            timeout
`endif
);

    localparam int              ERR_W    = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_VEC - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX  = ERR_W'(NUM_VEC);

    state_e              state_q;
    logic [ADDR_W-1:0]   idx_q;
    logic                start_q;
    logic [OP_W-1:0]     a_q;
    logic [OP_W-1:0]     b_q;
    logic [RES_W-1:0]    exp_q;
    logic                busy_q;
    logic                done_q;
    logic [ERR_W-1:0]    err_q;
    logic                fv_q;
    logic [ADDR_W-1:0]   fi_q;
    logic                miss;

`ifdef FUNC_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0]     wcnt_q;
    logic                to_hit_q;
    logic                timeout_q;

    // A watchdog expiry scores the vector as a mismatch regardless of the result bus.
    assign miss = (eng_result != exp_q) || to_hit_q;
    assign timeout = timeout_q;
`else
    assign miss = (eng_result != exp_q);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            start_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            exp_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= '0;
            fv_q      <= 1'b0;
            fi_q      <= '0;
`ifdef FUNC_SEQ_TIMEOUT_EN
            wcnt_q    <= '0;
            to_hit_q  <= 1'b0;
            timeout_q <= 1'b0;
`endif
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (run) begin
                        err_q     <= '0;
                        fv_q      <= 1'b0;
                        fi_q      <= '0;
                        idx_q     <= '0;
                        busy_q    <= 1'b1;
`ifdef FUNC_SEQ_TIMEOUT_EN
                        timeout_q <= 1'b0;
`endif
                        state_q   <= FETCH;
                    end
                end
                FETCH: begin
                    state_q <= LAUNCH;
                end
                LAUNCH: begin
                    a_q     <= vec_data[A_MSB -: OP_W];
                    b_q     <= vec_data[B_MSB -: OP_W];
                    exp_q   <= vec_data[EXP_MSB -: RES_W];
                    start_q <= 1'b1;
`ifdef FUNC_SEQ_TIMEOUT_EN
                    wcnt_q   <= '0;
                    to_hit_q <= 1'b0;
`endif
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (!eng_busy) begin
                        state_q <= CHECK;
                    end
`ifdef FUNC_SEQ_TIMEOUT_EN
                    else if (wcnt_q == TO_W'(TIMEOUT - 1)) begin
                        to_hit_q  <= 1'b1;
                        timeout_q <= 1'b1;
                        state_q   <= CHECK;
                    end else begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
`endif
                end
                CHECK: begin
                    if (miss) begin
                        if (err_q != ERR_MAX) begin
                            err_q <= err_q + 1'b1;
                        end
                        if (!fv_q) begin
                            fv_q <= 1'b1;
                            fi_q <= idx_q;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= FETCH;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign vec_addr   = idx_q;
    assign eng_start  = start_q;
    assign eng_a      = a_q;
    assign eng_b      = b_q;
    assign seq_busy   = busy_q;
    assign done       = done_q;
    assign err_count  = err_q;
    assign fail_valid = fv_q;
    assign fail_idx   = fi_q;

endmodule

// File: tb/tb_func_seq.sv
// Directed bench: two sequencers (NUM_VEC=1 and NUM_VEC=10) against a behavioural ROM and engine.
module tb_func_seq;

    logic        clk;
    logic        rst_n;
    logic        run        [2];
    logic [3:0]  vec_addr   [2];
    logic [31:0] vec_data   [2];
    logic        eng_start  [2];
    logic [7:0]  eng_a      [2];
    logic [7:0]  eng_b      [2];
    logic        eng_busy   [2];
    logic [15:0] eng_result [2];
    logic        seq_busy   [2];
    logic        done       [2];
    logic [4:0]  err_count  [2];
    logic        fail_valid [2];
    logic [3:0]  fail_idx   [2];
`ifdef FUNC_SEQ_TIMEOUT_EN
    logic        timeout    [2];
`endif

    logic [31:0] rom [16];
    int          cnt [2];
    int          lat;
    int          eng_mode;   // 0 normal, 1 busy stuck high, 2 zero-latency
    int          errors;
    int          checks;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        func_seq #(
            .NUM_VEC ((g == 0) ? 1 : 10),
            .ADDR_W  (4)
`ifdef FUNC_SEQ_TIMEOUT_EN
            , .TIMEOUT (16)
`endif
        ) u_dut (
            .clk        (clk),
            .reset      (rst_n),
            .run        (run[g]),
            .vec_addr   (vec_addr[g]),
            .vec_data   (vec_data[g]),
            .eng_start  (eng_start[g]),
            .eng_a      (eng_a[g]),
            .eng_b      (eng_b[g]),
            .eng_busy   (eng_busy[g]),
            .eng_result (eng_result[g]),
            .seq_busy   (seq_busy[g]),
            .done       (done[g]),
            .err_count  (err_count[g]),
            .fail_valid (fail_valid[g]),
            .fail_idx   (fail_idx[g])
`ifdef FUNC_SEQ_TIMEOUT_EN
            , .timeout  (timeout[g])
`endif
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] eng_model(input logic [7:0] a, input logic [7:0] b);
        int r;
        int ai;
        int bi;
        r  = 0;
        ai = int'(a);
        bi = int'(b);
        while ((r + 1) * (r + 1) * (r + 1) <= bi) r++;
        return 16'(ai * ai + r);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < 2; g++) cnt[g] <= 0;
        end else begin
            for (int g = 0; g < 2; g++) begin
                vec_data[g] <= rom[vec_addr[g]];
                if (eng_start[g]) cnt[g] <= lat;
                else if (cnt[g] != 0) cnt[g] <= cnt[g] - 1;
            end
        end
    end

    always_comb begin
        for (int g = 0; g < 2; g++) begin
            eng_busy[g]   = 1'b0;
            eng_result[g] = eng_model(eng_a[g], eng_b[g]);
            if (eng_mode == 1)      eng_busy[g] = 1'b1;
            else if (eng_mode == 0) eng_busy[g] = eng_start[g] || (cnt[g] != 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulses run, then samples each falling edge until done or the budget runs out.
    task automatic run_pass(input int k, input int budget, input bit poke,
                            output int nst, output int t0, output int gap,
                            output logic [7:0] fa, output logic [7:0] fb, output bit got);
        nst = 0; t0 = -1; gap = -1; fa = '0; fb = '0; got = 1'b0;
        @(negedge clk); run[k] = 1'b1;
        @(negedge clk); run[k] = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            if (eng_start[k]) begin
                nst++;
                if (nst == 1) begin t0 = c; fa = eng_a[k]; fb = eng_b[k]; end
                if (nst == 2) gap = c - t0;
            end
            if (done[k]) got = 1'b1;
            else begin
                if (poke && c == 30) run[k] = 1'b1;
                if (poke && c == 31) run[k] = 1'b0;
                @(negedge clk);
            end
        end
    endtask

    int          nst, t0, gap;
    logic [7:0]  fa, fb;
    bit          got;

    initial begin
        errors = 0; checks = 0;
        rst_n = 1'b0; run[0] = 1'b0; run[1] = 1'b0;
        lat = 3; eng_mode = 0;
        for (int i = 0; i < 16; i++) rom[i] = 32'h0;
        rom[0] = {8'd3,   8'd8,   16'd11};
        rom[1] = {8'd0,   8'd0,   16'd0};
        rom[2] = {8'd1,   8'd1,   16'd2};
        rom[3] = {8'd2,   8'd27,  16'd7};
        rom[4] = {8'd5,   8'd64,  16'd29};
        rom[5] = {8'd16,  8'd125, 16'd261};
        rom[6] = {8'd100, 8'd200, 16'd10005};
        rom[7] = {8'd10,  8'd10,  16'd102};
        rom[8] = {8'd200, 8'd100, 16'd40004};
        rom[9] = {8'd255, 8'd255, 16'd65031};

        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_busy%0d", k),  32'(seq_busy[k]),   0);
            chk($sformatf("rst_done%0d", k),  32'(done[k]),       0);
            chk($sformatf("rst_start%0d", k), 32'(eng_start[k]),  0);
            chk($sformatf("rst_addr%0d", k),  32'(vec_addr[k]),   0);
            chk($sformatf("rst_err%0d", k),   32'(err_count[k]),  0);
            chk($sformatf("rst_fv%0d", k),    32'(fail_valid[k]), 0);
            chk($sformatf("rst_a%0d", k),     32'(eng_a[k]),      0);
`ifdef FUNC_SEQ_TIMEOUT_EN
            chk($sformatf("rst_to%0d", k),    32'(timeout[k]),    0);
`endif
        end
        @(negedge clk); rst_n = 1'b1;

        // Single vector on the NUM_VEC=1 instance.
        run_pass(0, 100, 1'b0, nst, t0, gap, fa, fb, got);
        chk("v1_done", 32'(got), 1);
        chk("v1_t0", 32'(t0), 2);
        chk("v1_a", 32'(fa), 3);
        chk("v1_b", 32'(fb), 8);
        chk("v1_starts", 32'(nst), 1);
        chk("v1_err", 32'(err_count[0]), 0);
        chk("v1_fv", 32'(fail_valid[0]), 0);
        @(negedge clk);
        chk("v1_done_1cyc", 32'(done[0]), 0);
        chk("v1_idle", 32'(seq_busy[0]), 0);

        // Full set; a second run pulse mid-pass must not restart it.
        run_pass(1, 500, 1'b1, nst, t0, gap, fa, fb, got);
        chk("full_done", 32'(got), 1);
        chk("full_starts", 32'(nst), 10);
        chk("full_gap", 32'(gap), 8);
        chk("full_err", 32'(err_count[1]), 0);
        chk("full_fv", 32'(fail_valid[1]), 0);
        // run coinciding with the done pulse is dropped
        run[1] = 1'b1;
        @(negedge clk); run[1] = 1'b0;
        chk("run_at_done_busy", 32'(seq_busy[1]), 0);
        repeat (3) @(negedge clk);
        chk("run_at_done_start", 32'(eng_start[1]), 0);
        chk("run_at_done_busy2", 32'(seq_busy[1]), 0);

        // Vector 7 expects 103 but the engine yields 102.
        rom[7][15:0] = 16'd103;
        run_pass(1, 500, 1'b0, nst, t0, gap, fa, fb, got);
        chk("f7_done", 32'(got), 1);
        chk("f7_err", 32'(err_count[1]), 1);
        chk("f7_fv", 32'(fail_valid[1]), 1);
        chk("f7_idx", 32'(fail_idx[1]), 7);
        repeat (5) @(negedge clk);
        chk("f7_hold_err", 32'(err_count[1]), 1);
        chk("f7_hold_idx", 32'(fail_idx[1]), 7);

        // Two corrupt vectors: only the first is captured.
        rom[7][15:0] = 16'd102;
        rom[2][15:0] = 16'd3;
        rom[8][15:0] = 16'd40005;
        run_pass(1, 500, 1'b0, nst, t0, gap, fa, fb, got);
        chk("f28_done", 32'(got), 1);
        chk("f28_err", 32'(err_count[1]), 2);
        chk("f28_fv", 32'(fail_valid[1]), 1);
        chk("f28_idx", 32'(fail_idx[1]), 2);
        rom[2][15:0] = 16'd2;
        rom[8][15:0] = 16'd40004;

        // Engine that never raises busy: zero-latency completions.
        eng_mode = 2;
        run_pass(1, 500, 1'b0, nst, t0, gap, fa, fb, got);
        chk("zl_done", 32'(got), 1);
        chk("zl_starts", 32'(nst), 10);
        chk("zl_gap", 32'(gap), 4);
        chk("zl_err", 32'(err_count[1]), 0);
        eng_mode = 0;

        // Reset during WAIT of vector 4.
        @(negedge clk); run[1] = 1'b1;
        @(negedge clk); run[1] = 1'b0;
        nst = 0;
        for (int c = 0; c < 300 && nst < 5; c++) begin
            if (eng_start[1]) nst++;
            if (nst < 5) @(negedge clk);
        end
        chk("mr_reached_v4", 32'(nst), 5);
        chk("mr_addr", 32'(vec_addr[1]), 4);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_start", 32'(eng_start[1]), 0);
        chk("mr_busy", 32'(seq_busy[1]), 0);
        chk("mr_addr0", 32'(vec_addr[1]), 0);
        chk("mr_a", 32'(eng_a[1]), 0);
        chk("mr_b", 32'(eng_b[1]), 0);
        chk("mr_err", 32'(err_count[1]), 0);
        chk("mr_done", 32'(done[1]), 0);
        @(negedge clk); rst_n = 1'b1;
        run_pass(1, 500, 1'b0, nst, t0, gap, fa, fb, got);
        chk("mr_rerun_done", 32'(got), 1);
        chk("mr_rerun_t0", 32'(t0), 2);
        chk("mr_rerun_a", 32'(fa), 3);
        chk("mr_rerun_b", 32'(fb), 8);
        chk("mr_rerun_starts", 32'(nst), 10);
        chk("mr_rerun_err", 32'(err_count[1]), 0);

`ifdef FUNC_SEQ_TIMEOUT_EN
        // Busy stuck high: every vector times out.
        eng_mode = 1;
        run_pass(1, 1000, 1'b0, nst, t0, gap, fa, fb, got);
        chk("to_done", 32'(got), 1);
        chk("to_flag", 32'(timeout[1]), 1);
        chk("to_err", 32'(err_count[1]), 10);
        chk("to_idx", 32'(fail_idx[1]), 0);
        eng_mode = 0;
        run_pass(1, 500, 1'b0, nst, t0, gap, fa, fb, got);
        chk("to_cleared", 32'(timeout[1]), 0);
        chk("to_cleared_err", 32'(err_count[1]), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
